// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector with internal line buffers and a fixed 4-cycle pipeline.
// Threshold and magnitude mode are captured on the start-of-frame beat.
module sobel_edge_stream #(
  parameter int PIX_W   = 8,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int THR_DEF = 27,
  parameter bit EDGE_HI = 1'b0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_sof,
  input  logic [PIX_W+2:0] thr,
  input  logic             mode,
  output logic             edge_valid,
  output logic             edge_sof,
  output logic             edge_eol,
  output logic [PIX_W+2:0] edge_mag,
  output logic [PIX_W-1:0] edge_data,
  output logic             edge_bit
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 2;
  localparam int MW = PIX_W + 3;

  logic [CW-1:0] col_reg, cur_col, col_next;
  logic [RW-1:0] row_reg, cur_row, row_next;
  logic [MW-1:0] thr_q;
  logic          mode_q;

  // A sof beat overrides the running position so a frame can restart anywhere.
  always_comb begin
    cur_col  = pix_sof ? '0 : col_reg;
    cur_row  = pix_sof ? '0 : row_reg;
    col_next = cur_col + 1'b1;
    row_next = cur_row;
    if (cur_col == CW'(IMG_W - 1)) begin
      col_next = '0;
      row_next = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      col_reg <= '0;
      row_reg <= '0;
      thr_q   <= MW'(THR_DEF);
      mode_q  <= 1'b0;
    end else if (pix_valid) begin
      col_reg <= col_next;
      row_reg <= row_next;
      if (pix_sof) begin
        thr_q  <= thr;
        mode_q <= mode;
      end
    end
  end

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] rd0, rd1, pix_d;

  always_ff @(posedge sys_clk) begin
    if (pix_valid) begin
      rd0          <= lb0[cur_col];
      rd1          <= lb1[cur_col];
      pix_d        <= pix_data;
      lb0[cur_col] <= pix_data;
      lb1[cur_col] <= lb0[cur_col];
    end
  end

  // Tag bits per stage: [3] valid, [2] border, [1] sof, [0] eol.
  logic [3:0] tag_pipe [4];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 4; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= pix_valid ?
        {1'b1,
         (cur_row < RW'(2)) || (cur_col < CW'(2)),
         (cur_row == '0) && (cur_col == '0),
         cur_col == CW'(IMG_W - 1)} : 4'b0;
      for (int i = 1; i < 4; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Column element [2] is the oldest row (top), [0] the current row (bottom).
  logic [2:0][PIX_W-1:0] right_col, w_l, w_c, s1_l, s1_c, s1_r;
  logic [GW-1:0]         gx_p, gx_n, gy_p, gy_n, ax, ay;

  assign right_col = {rd1, rd0, pix_d};

  always_ff @(posedge sys_clk) begin
    if (tag_pipe[0][3]) begin
      w_l  <= w_c;
      w_c  <= right_col;
      s1_l <= w_l;
      s1_c <= w_c;
      s1_r <= right_col;
    end
    gx_p <= GW'(s1_r[2]) + GW'({s1_r[1], 1'b0}) + GW'(s1_r[0]);
    gx_n <= GW'(s1_l[2]) + GW'({s1_l[1], 1'b0}) + GW'(s1_l[0]);
    gy_p <= GW'(s1_l[2]) + GW'({s1_c[2], 1'b0}) + GW'(s1_r[2]);
    gy_n <= GW'(s1_l[0]) + GW'({s1_c[0], 1'b0}) + GW'(s1_r[0]);
    ax   <= (gx_p >= gx_n) ? gx_p - gx_n : gx_n - gx_p;
    ay   <= (gy_p >= gy_n) ? gy_p - gy_n : gy_n - gy_p;
  end

  logic [GW-1:0] mag_max;
  logic [MW-1:0] mag_c;
  logic          hit;

  always_comb begin
    mag_max = (ax >= ay) ? ax : ay;
    mag_c   = mode_q ? MW'(mag_max) : MW'(ax) + MW'(ay);
    if (tag_pipe[3][2]) mag_c = '0;
    hit     = !tag_pipe[3][2] && (mag_c >= thr_q);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      edge_valid <= 1'b0;
      edge_sof   <= 1'b0;
      edge_eol   <= 1'b0;
      edge_mag   <= '0;
      edge_data  <= '0;
      edge_bit   <= 1'b0;
    end else if (tag_pipe[3][3]) begin
      edge_valid <= 1'b1;
      edge_sof   <= tag_pipe[3][1];
      edge_eol   <= tag_pipe[3][0];
      edge_mag   <= mag_c;
      edge_bit   <= hit ? EDGE_HI : ~EDGE_HI;
      edge_data  <= {PIX_W{hit ? EDGE_HI : ~EDGE_HI}};
    end else begin
      edge_valid <= 1'b0;
      edge_sof   <= 1'b0;
      edge_eol   <= 1'b0;
      edge_mag   <= '0;
      edge_data  <= '0;
      edge_bit   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed bench for sobel_edge_stream on an 8x6 image: table of spot vectors plus
// sequences for flags, latency, gaps, threshold latching and mid-frame reset.
module tb_sobel_edge_stream;
  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int MW    = PIX_W + 3;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             pix_valid = 1'b0;
  logic [PIX_W-1:0] pix_data = '0;
  logic             pix_sof = 1'b0;
  logic [MW-1:0]    thr = MW'(27);
  logic             mode = 1'b0;
  logic             edge_valid, edge_sof, edge_eol, edge_bit;
  logic [MW-1:0]    edge_mag;
  logic [PIX_W-1:0] edge_data;

  sobel_edge_stream #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .THR_DEF(27), .EDGE_HI(1'b1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .thr(thr), .mode(mode), .edge_valid(edge_valid),
    .edge_sof(edge_sof), .edge_eol(edge_eol), .edge_mag(edge_mag),
    .edge_data(edge_data), .edge_bit(edge_bit)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int            out_cnt = 0;
  logic [MW-1:0] o_mag  [1024];
  logic [7:0]    o_data [1024];
  logic          o_bit  [1024];
  logic          o_sof  [1024];
  logic          o_eol  [1024];
  int            o_cyc  [1024];

  always @(negedge sys_clk) begin
    if (edge_valid === 1'b1 && out_cnt < 1024) begin
      o_mag[out_cnt]  = edge_mag;
      o_data[out_cnt] = edge_data;
      o_bit[out_cnt]  = edge_bit;
      o_sof[out_cnt]  = edge_sof;
      o_eol[out_cnt]  = edge_eol;
      o_cyc[out_cnt]  = cyc;
      out_cnt++;
    end
  end

  int in_cnt = 0;
  int i_cyc [1024];
  int fin_base [16];
  int fout_base [16];
  int nf = 0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'd100;
      1:       return (c >= 4) ? 8'd200 : 8'd0;
      2:       return (c >= r) ? 8'd200 : 8'd0;
      default: return (c >= 4) ? 8'd10 : 8'd0;
    endcase
  endfunction

  // Vertical 0->200 step at column 4: only windows straddling it (inputs c=4,5) respond.
  function automatic int vstep_mag(input int r, input int c);
    return (r >= 2 && (c == 4 || c == 5)) ? 800 : 0;
  endfunction

  task automatic send_frame(input int pat, input int t, input bit m, input bit gaps,
                            input int chg_at, input int npix);
    fin_base[nf]  = in_cnt;
    fout_base[nf] = out_cnt;
    nf++;
    for (int k = 0; k < npix; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          @(negedge sys_clk);
          pix_valid = 1'b0;
          pix_sof   = 1'b0;
        end
      end
      @(negedge sys_clk);
      pix_valid = 1'b1;
      pix_sof   = (k == 0);
      pix_data  = pix(pat, k / IMG_W, k % IMG_W);
      if (k == 0) begin
        thr  = MW'(t);
        mode = m;
      end
      if (k == chg_at) thr = MW'(41);
      i_cyc[in_cnt] = cyc + 1;
      in_cnt++;
    end
    @(negedge sys_clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic idle_check(input int n);
    repeat (n) @(negedge sys_clk);
    chk("idle_valid", edge_valid, 0);
    chk("idle_mag", edge_mag, 0);
  endtask

  task automatic frame_done(input int f);
    idle_check(8);
    chk($sformatf("frame%0d_count", f), out_cnt - fout_base[f], NPIX);
  endtask

  typedef struct {
    int f;
    int r;
    int c;
    int mag;
    bit eb;
  } vec_t;

  vec_t vecs [32];
  int   nv = 0;

  task automatic addv(input int f, input int r, input int c, input int mag, input bit eb);
    vecs[nv] = '{f, r, c, mag, eb};
    nv++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int rst_base;

    addv(0, 3, 4, 0, 0);     addv(0, 5, 7, 0, 0);
    addv(1, 2, 4, 800, 1);   addv(1, 5, 5, 800, 1);   addv(1, 3, 6, 0, 0);
    addv(1, 4, 7, 0, 0);     addv(1, 1, 4, 0, 0);     addv(1, 0, 5, 0, 0);
    addv(2, 3, 4, 800, 1);   addv(2, 4, 5, 800, 1);
    addv(3, 2, 2, 1200, 1);  addv(3, 3, 4, 400, 1);   addv(3, 4, 2, 400, 1);
    addv(3, 5, 5, 1200, 1);
    addv(4, 2, 2, 600, 1);   addv(4, 3, 4, 200, 1);   addv(4, 5, 5, 600, 1);
    addv(5, 2, 4, 40, 1);    addv(5, 4, 5, 40, 1);
    addv(6, 2, 4, 40, 0);    addv(6, 4, 5, 40, 0);
    addv(8, 2, 4, 40, 1);    addv(8, 5, 5, 40, 1);
    addv(9, 3, 4, 40, 0);
    addv(11, 2, 4, 800, 1);

    repeat (3) @(negedge sys_clk);
    chk("rst_valid", edge_valid, 0);
    chk("rst_mag", edge_mag, 0);
    chk("rst_data", edge_data, 0);
    chk("rst_bit", edge_bit, 0);
    chk("rst_flags", {edge_sof, edge_eol}, 0);
    #1 sys_rst = 1'b0;

    send_frame(0, 27, 0, 0, -1, NPIX);  frame_done(0);
    send_frame(1, 27, 0, 0, -1, NPIX);  frame_done(1);
    send_frame(1, 27, 1, 0, -1, NPIX);  frame_done(2);
    send_frame(2, 27, 0, 0, -1, NPIX);  frame_done(3);
    send_frame(2, 27, 1, 0, -1, NPIX);  frame_done(4);
    send_frame(3, 40, 0, 0, -1, NPIX);  frame_done(5);
    send_frame(3, 41, 0, 0, -1, NPIX);  frame_done(6);
    send_frame(1, 27, 0, 1, -1, NPIX);  frame_done(7);
    send_frame(3, 40, 0, 0, 10, NPIX);  frame_done(8);
    send_frame(3, 41, 0, 0, -1, NPIX);  frame_done(9);

    // Partial diagonal frame, reset while results are still in flight.
    send_frame(2, 27, 0, 0, -1, 20);
    chk("pre_rst_valid", edge_valid, 1);
    rst_base = fout_base[10];
    #1 sys_rst = 1'b1;
    #1;
    chk("mid_rst_valid", edge_valid, 0);
    chk("mid_rst_mag", edge_mag, 0);
    chk("mid_rst_bit", edge_bit, 0);
    chk("partial_count", out_cnt - rst_base, 16);
    repeat (2) @(negedge sys_clk);
    #1 sys_rst = 1'b0;
    idle_check(8);
    chk("no_stale_output", out_cnt - rst_base, 16);
    send_frame(1, 27, 0, 0, -1, NPIX);  frame_done(11);

    for (int v = 0; v < nv; v++) begin
      idx = fout_base[vecs[v].f] + vecs[v].r * IMG_W + vecs[v].c;
      chk($sformatf("vec%0d_mag", v), o_mag[idx], vecs[v].mag);
      chk($sformatf("vec%0d_bit", v), o_bit[idx], vecs[v].eb);
      chk($sformatf("vec%0d_data", v), o_data[idx], vecs[v].eb ? 255 : 0);
      $display("vec %0d frame=%0d r=%0d c=%0d mag=%0d bit=%0d", v, vecs[v].f, vecs[v].r,
               vecs[v].c, o_mag[idx], o_bit[idx]);
    end

    for (int k = 0; k < NPIX; k++) begin
      idx = fout_base[0] + k;
      chk($sformatf("flat%0d_mag", k), o_mag[idx], 0);
      chk($sformatf("flat%0d_bit", k), o_bit[idx], 0);
      chk($sformatf("flat%0d_sof", k), o_sof[idx], (k == 0) ? 1 : 0);
      chk($sformatf("flat%0d_eol", k), o_eol[idx], (k % IMG_W == IMG_W - 1) ? 1 : 0);
      chk($sformatf("flat%0d_lat", k), o_cyc[idx] - i_cyc[fin_base[0] + k], 4);
    end

    for (int k = 0; k < NPIX; k++) begin
      chk($sformatf("vstep%0d_mag", k), o_mag[fout_base[1] + k], vstep_mag(k / IMG_W, k % IMG_W));
      chk($sformatf("gaps%0d_mag", k), o_mag[fout_base[7] + k], vstep_mag(k / IMG_W, k % IMG_W));
      chk($sformatf("gaps%0d_bit", k), o_bit[fout_base[7] + k],
          (vstep_mag(k / IMG_W, k % IMG_W) != 0) ? 1 : 0);
      chk($sformatf("gaps%0d_lat", k), o_cyc[fout_base[7] + k] - i_cyc[fin_base[7] + k], 4);
      chk($sformatf("gaps%0d_sof", k), o_sof[fout_base[7] + k], (k == 0) ? 1 : 0);
      chk($sformatf("post_rst%0d_mag", k), o_mag[fout_base[11] + k],
          vstep_mag(k / IMG_W, k % IMG_W));
      chk($sformatf("post_rst%0d_bit", k), o_bit[fout_base[11] + k],
          (vstep_mag(k / IMG_W, k % IMG_W) != 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
